// File: rtl/lpddr2_bridge.sv
// rtl/lpddr2_bridge.sv - single-word request port to Avalon-MM LPDDR2 controller bridge
// One-entry read buffer serves repeated reads of the same word without a controller access.
module lpddr2_bridge #(
  parameter int ADDR_W  = 27,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W-1:0]   write_data,
  input  logic                read_req,
  input  logic                write_req,
  output logic [DATA_W-1:0]   read_data,
  output logic                stall,
  output logic                err,
  output logic [ADDR_W-1:0]   avl_address,
  output logic [DATA_W-1:0]   avl_wdata,
  output logic                avl_read,
  output logic                avl_write,
  output logic [DATA_W/8-1:0] avl_be,
  input  logic                avl_ready,
  input  logic [DATA_W-1:0]   avl_rdata,
  input  logic                avl_rdata_valid,
  input  logic                local_init_done
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [DATA_W-1:0] BAD_DATA = DATA_W'(32'hDEADBEEF);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_CMD,
    S_RD_CMD,
    S_RD_WAIT,
    S_ACK
  } state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   req_addr;
  logic [DATA_W-1:0]   req_data;
  logic                buf_valid;
  logic [ADDR_W-1:0]   buf_addr;
  logic [DATA_W-1:0]   buf_data;
  logic [CNT_W-1:0]    cnt;
  logic                to_flag;
  logic                hit;
  logic                rd_timeout;
  logic                latch_req;
  logic                stall_c;

  assign hit        = read_req && buf_valid && (buf_addr == address);
  assign rd_timeout = (state == S_RD_WAIT) && !avl_rdata_valid && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    latch_req = 1'b0;
    stall_c   = 1'b0;
    case (state)
      S_IDLE: begin
        if (!local_init_done) begin
          stall_c = read_req | write_req;
        end else if (write_req) begin
          stall_c   = 1'b1;
          latch_req = 1'b1;
          state_nxt = S_WR_CMD;
        end else if (hit) begin
          stall_c = 1'b0;
        end else if (read_req) begin
          stall_c   = 1'b1;
          latch_req = 1'b1;
          state_nxt = S_RD_CMD;
        end
      end
      S_WR_CMD: begin
        stall_c = 1'b1;
        if (avl_ready) state_nxt = S_ACK;
      end
      S_RD_CMD: begin
        stall_c = 1'b1;
        if (avl_ready) state_nxt = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        stall_c = 1'b1;
        if (avl_rdata_valid || rd_timeout) state_nxt = S_ACK;
      end
      S_ACK:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_addr  <= '0;
      req_data  <= '0;
      buf_valid <= 1'b0;
      buf_addr  <= '0;
      buf_data  <= '0;
      cnt       <= '0;
      err       <= 1'b0;
      to_flag   <= 1'b0;
    end else begin
      if (latch_req) begin
        req_addr <= address;
        req_data <= write_data;
      end
      // Remembers that the coming ACK answers an abandoned read
      to_flag <= rd_timeout;
      case (state)
        S_WR_CMD: begin
          if (avl_ready && buf_valid && (buf_addr == req_addr)) buf_data <= req_data;
        end
        S_RD_CMD: begin
          if (avl_ready) cnt <= '0;
        end
        S_RD_WAIT: begin
          if (avl_rdata_valid) begin
            buf_addr  <= req_addr;
            buf_data  <= avl_rdata;
            buf_valid <= 1'b1;
          end else if (rd_timeout) begin
            buf_valid <= 1'b0;
            err       <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign stall       = stall_c && !rst;
  assign read_data   = rst ? '0 : ((state == S_ACK) && to_flag) ? BAD_DATA : buf_data;
  assign avl_address = req_addr;
  assign avl_wdata   = req_data;
  assign avl_read    = (state == S_RD_CMD);
  assign avl_write   = (state == S_WR_CMD);
  assign avl_be      = '1;

endmodule

// File: doc/lpddr2_bridge.md
# lpddr2_bridge

Responder end of the memory master's LPDDR2 request port. Accepts single-word `read_req`/`write_req` commands with a 27-bit word address and returns `read_data`. Converts each command into one Avalon-MM transaction towards the LPDDR2 controller and asserts `stall` until it completes. A one-entry read buffer answers repeated reads of the same word without a new controller transaction.

## Interface
Parameters:
- `ADDR_W`, 27, word-address width on both sides
- `DATA_W`, 32, data width
- `TIMEOUT`, 1024, maximum cycles in RD_WAIT before the read is abandoned

Ports:
- `clk`  in  1  system clock; every edge below is `clk`
- `rst`  in  1  synchronous, active-high reset
- `address`  in  ADDR_W  word address from the memory master
- `write_data`  in  DATA_W  store data
- `read_req`  in  1  read request; level, held while `stall`=1
- `write_req`  in  1  write request; level, held while `stall`=1
- `read_data`  out  DATA_W  read result
- `stall`  out  1  request not yet served; CPU must hold state
- `err`  out  1  sticky read-timeout flag
- `avl_address`  out  ADDR_W  controller address
- `avl_wdata`  out  DATA_W  controller write data
- `avl_read`  out  1  controller read command
- `avl_write`  out  1  controller write command
- `avl_be`  out  DATA_W/8  byte enables; constant all-ones
- `avl_ready`  in  1  controller accepts the current command
- `avl_rdata`  in  DATA_W  controller read data
- `avl_rdata_valid`  in  1  `avl_rdata` valid this cycle
- `local_init_done`  in  1  controller calibration complete

## Operation
- Request latch: `req_addr` and `req_data` are captured on leaving IDLE. `avl_address` and `avl_wdata` are always driven from this latch.
- Read buffer: `buf_valid`, `buf_addr`, `buf_data`. A hit is `read_req && buf_valid && buf_addr==address`.
- State IDLE:
  - If `local_init_done`=0, then `stall` = `read_req|write_req`.
  - Else if `write_req`, latch the request and go to WR_CMD. `write_req` has priority over a simultaneous `read_req`.
  - Else if the read hits, `stall`=0 and `read_data`=`buf_data`.
  - Else if `read_req`, latch the address and go to RD_CMD.
- State WR_CMD: `avl_write`=1. When `avl_ready`=1:
  - If `buf_valid && buf_addr==req_addr`, set `buf_data` ← `req_data` (write-through update).
  - Go to ACK.
- State RD_CMD: `avl_read`=1. When `avl_ready`=1, clear the timeout counter and go to RD_WAIT.
- State RD_WAIT: no command driven.
  - On `avl_rdata_valid`: `buf_addr` ← `req_addr`, `buf_data` ← `avl_rdata`, `buf_valid` ← 1, go to ACK.
  - If the counter reaches TIMEOUT-1 without `avl_rdata_valid`: `buf_valid` ← 0, `err` ← 1, `read_data` for this response = 32'hDEADBEEF, go to ACK.
- State ACK: `stall`=0 for exactly one cycle. `read_data`=`buf_data`, except after a timeout as above. Then return to IDLE.
- `stall` is 1 in WR_CMD, RD_CMD and RD_WAIT.
- `avl_rdata_valid` arriving in any state other than RD_WAIT is ignored.
- `err` clears only on `rst`.
- Address arithmetic is pure pass-through. No wrap, offset or width change.

## Timing
- Reset values: state IDLE, `avl_read`=0, `avl_write`=0, `buf_valid`=0, `buf_addr`=0, `buf_data`=0, `read_data`=0, `err`=0.
- `stall` is forced to 0 while `rst`=1.
- A reset asserted in the middle of an operation aborts it within the same edge: commands drop, the buffer is invalidated, and a late `avl_rdata_valid` is ignored.
- `stall`, `read_data` on a hit, and the IDLE decisions are combinational from the current state and inputs. All Avalon outputs are Moore outputs of the registered state.
- Read hit: zero added cycles; `stall`=0 in the request cycle.
- Read miss, with `avl_ready`=1 immediately and `avl_rdata_valid` k cycles after acceptance (k≥1):
  - Cycle 0: IDLE, `stall`=1.
  - Cycle 1: RD_CMD, `avl_read`=1.
  - Cycles 2..k+1: RD_WAIT.
  - Cycle k+2: ACK, `stall`=0.
  - Total `stall`-high cycles: k+2.
- Write, with `avl_ready`=1 immediately:
  - Cycle 0: IDLE, `stall`=1.
  - Cycle 1: WR_CMD, `avl_write`=1.
  - Cycle 2: ACK, `stall`=0.
- Each `avl_ready`=0 cycle in RD_CMD or WR_CMD adds one stall cycle. The command and address hold stable while `avl_ready`=0.
- The master holds `address`, `write_data` and the request while stalled. The bridge uses only the latched copies after IDLE.

## Test plan
- Reset, then `local_init_done`=1, `read_req`=1, `address`=0x100, `avl_ready`=1, `avl_rdata`=0xCAFEF00D with `avl_rdata_valid` 3 cycles after acceptance -> `stall` high 5 cycles; ACK shows `read_data`=0xCAFEF00D; exactly one `avl_read` pulse with `avl_address`=0x100.
- Repeat the read of 0x100 -> `stall`=0 in the same cycle, `read_data`=0xCAFEF00D, no `avl_read` issued.
- `write_req` to 0x100 with 0x12345678, `avl_ready` low for 2 cycles -> `avl_write` held 3 cycles with stable address and data; `stall` high 4 cycles; the following read of 0x100 hits and returns 0x12345678.
- `write_req` and `read_req` together at 0x200 -> only `avl_write` issued; no read transaction.
- Read miss at 0x300 with `avl_rdata_valid` never asserted -> after TIMEOUT cycles in RD_WAIT, ACK returns 0xDEADBEEF and `err`=1 (sticky); the next read of 0x300 misses.
- `rst` asserted in RD_WAIT, then `avl_rdata_valid` pulsed → outputs at reset values, `buf_valid`=0, and the late data does not load the buffer.
